// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue stage in front of the ALU.
// Decodes an RV32I instruction into the ALU control code and operands, then
// registers the bundle behind a valid/ready handshake. A one-entry skid buffer
// lets in_ready be a pure flop while still sustaining one transfer per cycle.
module alu_issue_stage #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC_VAL = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      alu_ctrl,
    output logic [4:0]      rd,
    output logic            reg_we,
    output logic            is_branch,
    output logic            is_jump,
    output logic [XLEN-1:0] link_addr,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal
);

    localparam logic [4:0] C_ADD  = 5'b00000, C_SUB  = 5'b00001, C_AND  = 5'b00010;
    localparam logic [4:0] C_OR   = 5'b00011, C_XOR  = 5'b00100, C_SLT  = 5'b00101;
    localparam logic [4:0] C_SLL  = 5'b00110, C_SRL  = 5'b00111, C_SRA  = 5'b01000;
    localparam logic [4:0] C_SLLI = 5'b01001, C_SRAI = 5'b01010, C_ADDI = 5'b01100;
    localparam logic [4:0] C_SLTI = 5'b01101, C_SLTIU = 5'b01110, C_XORI = 5'b01111;
    localparam logic [4:0] C_SRLI = 5'b10000, C_ORI  = 5'b10001, C_ANDI = 5'b10010;
    localparam logic [4:0] C_JALR = 5'b10011, C_SLTU = 5'b10100;

    localparam logic [6:0] OP_REG = 7'b0110011, OP_IMM  = 7'b0010011, OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      ctrl;
        logic [4:0]      rd;
        logic            we;
        logic            br;
        logic            jmp;
        logic            ill;
        logic [XLEN-1:0] link;
        logic [XLEN-1:0] pcv;
    } bundle_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [31:0] imm_i, imm_s, imm_u, imm_j, shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign shamt  = {27'b0, instr[24:20]};

    bundle_t dec;

    // Combinational decode of the presented instruction into an issue bundle.
    always_comb begin
        dec      = '0;
        dec.rd   = instr[11:7];
        dec.link = pc + 32'd4;
        dec.pcv  = pc;
        case (opcode)
            OP_REG: begin
                dec.a  = rs1_data;
                dec.b  = rs2_data;
                dec.we = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec.ctrl = C_ADD;
                        3'b001:  dec.ctrl = C_SLL;
                        3'b010:  dec.ctrl = C_SLT;
                        3'b011:  dec.ctrl = C_SLTU;
                        3'b100:  dec.ctrl = C_XOR;
                        3'b101:  dec.ctrl = C_SRL;
                        3'b110:  dec.ctrl = C_OR;
                        default: dec.ctrl = C_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec.ctrl = C_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec.ctrl = C_SRA;
                end else begin
                    dec.ill = 1'b1;
                end
            end
            OP_IMM: begin
                dec.a  = rs1_data;
                dec.b  = imm_i;
                dec.we = 1'b1;
                case (funct3)
                    3'b000: dec.ctrl = C_ADDI;
                    3'b010: dec.ctrl = C_SLTI;
                    3'b011: dec.ctrl = C_SLTIU;
                    3'b100: dec.ctrl = C_XORI;
                    3'b110: dec.ctrl = C_ORI;
                    3'b111: dec.ctrl = C_ANDI;
                    3'b001: begin
                        dec.b    = shamt;
                        dec.ctrl = C_SLLI;
                        dec.ill  = (funct7 != 7'b0000000);
                    end
                    default: begin
                        dec.b = shamt;
                        if (funct7 == 7'b0000000)      dec.ctrl = C_SRLI;
                        else if (funct7 == 7'b0100000) dec.ctrl = C_SRAI;
                        else                           dec.ill  = 1'b1;
                    end
                endcase
            end
            OP_LUI: begin
                dec.b  = imm_u;
                dec.we = 1'b1;
            end
            OP_AUIPC: begin
                dec.a  = pc;
                dec.b  = imm_u;
                dec.we = 1'b1;
            end
            OP_JAL: begin
                dec.a   = pc;
                dec.b   = imm_j;
                dec.jmp = 1'b1;
                dec.we  = 1'b1;
            end
            OP_JALR: begin
                dec.a    = rs1_data;
                dec.b    = imm_i;
                dec.ctrl = C_JALR;
                dec.jmp  = 1'b1;
                dec.we   = 1'b1;
            end
            OP_LOAD: begin
                dec.a  = rs1_data;
                dec.b  = imm_i;
                dec.we = 1'b1;
            end
            OP_STORE: begin
                dec.a = rs1_data;
                dec.b = imm_s;
            end
            OP_BRANCH: begin
                dec.a  = rs1_data;
                dec.b  = rs2_data;
                dec.br = 1'b1;
                case (funct3[2:1])
                    2'b00:   dec.ctrl = C_SUB;
                    2'b10:   dec.ctrl = C_SLT;
                    2'b11:   dec.ctrl = C_SLTU;
                    default: dec.ill  = 1'b1;
                endcase
            end
            default: dec.ill = 1'b1;
        endcase
        // An unsupported encoding issues as an inert bubble-like bundle.
        if (dec.ill) begin
            dec.a    = '0;
            dec.b    = '0;
            dec.ctrl = C_ADD;
            dec.we   = 1'b0;
            dec.br   = 1'b0;
            dec.jmp  = 1'b0;
        end
        if (dec.rd == 5'd0) dec.we = 1'b0;
    end

    bundle_t out_q, out_d, skid_q, skid_d;
    logic    out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, in_ready_q, in_ready_d;
    logic    accept, consume;

    assign accept  = in_valid & in_ready_q;
    assign consume = out_vld_q & ex_ready;

    // Next-state for output register and skid buffer; flush overrides everything.
    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!out_vld_q || consume) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = accept;
                if (accept) skid_d = dec;
            end else begin
                out_vld_d = accept;
                if (accept) out_d = dec;
            end
        end else if (accept) begin
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end
        in_ready_d = ~skid_vld_d;
    end

    // State registers with asynchronous reset to an empty, ready stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_q.pcv   <= RESET_PC_VAL;
            skid_q      <= '0;
            out_vld_q   <= 1'b0;
            skid_vld_q  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_vld_q   <= out_vld_d;
            skid_vld_q  <= skid_vld_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign ex_valid  = out_vld_q;
    assign alu_a     = out_q.a;
    assign alu_b     = out_q.b;
    assign alu_ctrl  = out_q.ctrl;
    assign rd        = out_q.rd;
    assign reg_we    = out_q.we;
    assign is_branch = out_q.br;
    assign is_jump   = out_q.jmp;
    assign illegal   = out_q.ill;
    assign link_addr = out_q.link;
    assign pc_out    = out_q.pcv;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed decode table, handshake/flush/reset
// sequences, and randomized traffic checked against a queue-based model.
module tb_alu_issue_stage;

    logic        clk, rst_n, flush, in_valid, in_ready, ex_valid, ex_ready;
    logic [31:0] instr, pc, rs1_data, rs2_data, alu_a, alu_b, link_addr, pc_out;
    logic [4:0]  alu_ctrl, rd;
    logic        reg_we, is_branch, is_jump, illegal;

    alu_issue_stage #(.XLEN(32), .RESET_PC_VAL(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctrl(alu_ctrl), .rd(rd), .reg_we(reg_we), .is_branch(is_branch),
        .is_jump(is_jump), .link_addr(link_addr), .pc_out(pc_out), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] a, b;
        logic [4:0]  ctrl, rd;
        logic        we, br, jmp, ill;
        logic [31:0] link, pcv;
    } exp_t;

    exp_t q[$];

    typedef struct {
        logic [31:0] ins, pcv, r1, r2, a, b;
        logic [4:0]  ctrl, rd;
        logic        we, br, jmp, ill;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference decode built from the ISA rules with lookup tables and integer arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] ins, pcv, r1, r2);
        exp_t       e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        int         iimm, simm, jimm;
        logic [4:0] reg_ops[8];
        logic [4:0] imm_ops[8];
        reg_ops = '{5'd0, 5'd6, 5'd5, 5'd20, 5'd4, 5'd7, 5'd3, 5'd2};
        imm_ops = '{5'd12, 5'd9, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18};
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        iimm = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
        simm = (ins[31] ? -2048 : 0) + int'(ins[30:25]) * 32 + int'(ins[11:7]);
        jimm = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
               + int'(ins[30:21]) * 2;
        e = '0;
        e.rd = ins[11:7]; e.link = pcv + 32'd4; e.pcv = pcv;
        case (op)
            7'h33: begin
                e.a = r1; e.b = r2; e.we = 1'b1;
                if (f7 == 7'h00)                  e.ctrl = reg_ops[f3];
                else if (f7 == 7'h20 && f3 == 0)  e.ctrl = 5'd1;
                else if (f7 == 7'h20 && f3 == 5)  e.ctrl = 5'd8;
                else                              e.ill = 1'b1;
            end
            7'h13: begin
                e.a = r1; e.we = 1'b1; e.b = 32'(iimm); e.ctrl = imm_ops[f3];
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.b = 32'(ins[24:20]);
                    if (f7 == 7'h20 && f3 == 3'd5) e.ctrl = 5'd10;
                    else if (f7 != 7'h00)          e.ill = 1'b1;
                end
            end
            7'h37: begin e.b = ins & 32'hFFFF_F000; e.we = 1'b1; end
            7'h17: begin e.a = pcv; e.b = ins & 32'hFFFF_F000; e.we = 1'b1; end
            7'h6F: begin e.a = pcv; e.b = 32'(jimm); e.jmp = 1'b1; e.we = 1'b1; end
            7'h67: begin e.a = r1; e.b = 32'(iimm); e.ctrl = 5'd19; e.jmp = 1'b1; e.we = 1'b1; end
            7'h03: begin e.a = r1; e.b = 32'(iimm); e.we = 1'b1; end
            7'h23: begin e.a = r1; e.b = 32'(simm); end
            7'h63: begin
                e.a = r1; e.b = r2; e.br = 1'b1;
                if (f3 == 3'd0 || f3 == 3'd1)      e.ctrl = 5'd1;
                else if (f3 == 3'd4 || f3 == 3'd5) e.ctrl = 5'd5;
                else if (f3 == 3'd6 || f3 == 3'd7) e.ctrl = 5'd20;
                else                               e.ill = 1'b1;
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.a = '0; e.b = '0; e.ctrl = '0; e.we = 1'b0; e.br = 1'b0; e.jmp = 1'b0;
        end
        if (e.rd == 5'd0) e.we = 1'b0;
        return e;
    endfunction

    task automatic check_model();
        exp_t e;
        chk("ex_valid", 32'(ex_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            e = q[0];
            chk("alu_a", alu_a, e.a);
            chk("alu_b", alu_b, e.b);
            chk("alu_ctrl", 32'(alu_ctrl), 32'(e.ctrl));
            chk("rd", 32'(rd), 32'(e.rd));
            chk("flags", {28'b0, reg_we, is_branch, is_jump, illegal}, {28'b0, e.we, e.br, e.jmp, e.ill});
            chk("link_addr", link_addr, e.link);
            chk("pc_out", pc_out, e.pcv);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pcv,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic rdy, input logic fl);
        logic acc, cons;
        in_valid = v; instr = ins; pc = pcv; rs1_data = r1; rs2_data = r2;
        ex_ready = rdy; flush = fl;
        @(posedge clk);
        acc  = v && (q.size() < 2);
        cons = (q.size() > 0) && rdy;
        if (fl) q.delete();
        else begin
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(ins, pcv, r1, r2));
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic add_vec(input logic [31:0] ins, r1, a, b, input logic [4:0] ctrl, rdv,
                           input logic we, br, jmp, ill);
        vec_t v;
        v.ins = ins; v.pcv = 32'h100; v.r1 = r1; v.r2 = 32'd3; v.a = a; v.b = b;
        v.ctrl = ctrl; v.rd = rdv; v.we = we; v.br = br; v.jmp = jmp; v.ill = ill;
        vt.push_back(v);
    endtask

    localparam logic [31:0] I_A = 32'h0010_0293, I_B = 32'h0020_0313, I_C = 32'h0030_0393;

    initial begin
        logic [6:0]  opl[9];
        logic [31:0] ri;
        opl = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63};

        //            instr          rs1    a             b             ctrl    rd     we br jmp ill
        add_vec(32'h402080B3, 32'd5, 32'd5,        32'd3,        5'h01, 5'd1,  1, 0, 0, 0);
        add_vec(32'hFFF00113, 32'd0, 32'd0,        32'hFFFFFFFF, 5'h0C, 5'd2,  1, 0, 0, 0);
        add_vec(32'h4030D093, 32'd5, 32'd5,        32'd3,        5'h0A, 5'd1,  1, 0, 0, 0);
        add_vec(32'hFFFFFFFF, 32'd5, 32'd0,        32'd0,        5'h00, 5'd31, 0, 0, 0, 1);
        add_vec(32'h0020F463, 32'd5, 32'd5,        32'd3,        5'h14, 5'd8,  0, 1, 0, 0);
        add_vec(32'h0020C463, 32'd5, 32'd5,        32'd3,        5'h05, 5'd8,  0, 1, 0, 0);
        add_vec(32'h002081B3, 32'd5, 32'd5,        32'd3,        5'h00, 5'd3,  1, 0, 0, 0);
        add_vec(32'h123452B7, 32'd5, 32'd0,        32'h12345000, 5'h00, 5'd5,  1, 0, 0, 0);
        add_vec(32'h00001317, 32'd5, 32'h100,      32'h1000,     5'h00, 5'd6,  1, 0, 0, 0);
        add_vec(32'h010000EF, 32'd5, 32'h100,      32'd16,       5'h00, 5'd1,  1, 0, 1, 0);
        add_vec(32'h0100006F, 32'd5, 32'h100,      32'd16,       5'h00, 5'd0,  0, 0, 1, 0);
        add_vec(32'h004100E7, 32'd5, 32'd5,        32'd4,        5'h13, 5'd1,  1, 0, 1, 0);
        add_vec(32'hFF80A383, 32'd5, 32'd5,        32'hFFFFFFF8, 5'h00, 5'd7,  1, 0, 0, 0);
        add_vec(32'h0020A623, 32'd5, 32'd5,        32'd12,       5'h00, 5'd12, 0, 0, 0, 0);
        add_vec(32'h022081B3, 32'd5, 32'd0,        32'd0,        5'h00, 5'd3,  0, 0, 0, 1);
        add_vec(32'h0020A463, 32'd5, 32'd0,        32'd0,        5'h00, 5'd8,  0, 0, 0, 1);
        add_vec(32'h4020D1B3, 32'd5, 32'd5,        32'd3,        5'h08, 5'd3,  1, 0, 0, 0);
        add_vec(32'h40109093, 32'd5, 32'd0,        32'd0,        5'h00, 5'd1,  0, 0, 0, 1);
        add_vec(32'h0070B213, 32'd5, 32'd5,        32'd7,        5'h0E, 5'd4,  1, 0, 0, 0);
        add_vec(32'h00208033, 32'd5, 32'd5,        32'd3,        5'h00, 5'd0,  0, 0, 0, 0);

        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
        instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        #2 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        rst_n = 1'b1;
        q.delete();

        // Directed decode table, one instruction per cycle with EX always ready.
        foreach (vt[i]) begin
            cycle(1'b1, vt[i].ins, vt[i].pcv, vt[i].r1, vt[i].r2, 1'b1, 1'b0);
            chk($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'd1);
            chk($sformatf("vec%0d_a", i), alu_a, vt[i].a);
            chk($sformatf("vec%0d_b", i), alu_b, vt[i].b);
            chk($sformatf("vec%0d_ctrl", i), 32'(alu_ctrl), 32'(vt[i].ctrl));
            chk($sformatf("vec%0d_rd", i), 32'(rd), 32'(vt[i].rd));
            chk($sformatf("vec%0d_flags", i), {28'b0, reg_we, is_branch, is_jump, illegal},
                {28'b0, vt[i].we, vt[i].br, vt[i].jmp, vt[i].ill});
        end
        cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);

        // Stall: A to output, B to skid, C held until the stage drains.
        cycle(1'b1, I_A, 32'h200, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("stall_A_rd", 32'(rd), 32'd5);
        chk("stall_A_ready", 32'(in_ready), 32'd1);
        cycle(1'b1, I_B, 32'h204, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("stall_B_ready", 32'(in_ready), 32'd0);
        chk("stall_hold_rd", 32'(rd), 32'd5);
        cycle(1'b1, I_C, 32'h208, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("stall_C_held_rd", 32'(rd), 32'd5);
        chk("stall_C_held_b", alu_b, 32'd1);
        cycle(1'b1, I_C, 32'h208, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("drain_B_rd", 32'(rd), 32'd6);
        chk("drain_B_ready", 32'(in_ready), 32'd1);
        cycle(1'b1, I_C, 32'h208, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("drain_C_rd", 32'(rd), 32'd7);
        chk("drain_C_pc", pc_out, 32'h208);
        cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
        chk("drain_empty", 32'(ex_valid), 32'd0);

        // Flush with output and skid both full, input presented.
        cycle(1'b1, I_A, 32'h300, 32'd0, 32'd0, 1'b0, 1'b0);
        cycle(1'b1, I_B, 32'h304, 32'd0, 32'd0, 1'b0, 1'b0);
        cycle(1'b1, I_C, 32'h308, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        // Flush while the stage is ready: the presented instruction is dropped.
        cycle(1'b1, I_A, 32'h310, 32'd0, 32'd0, 1'b0, 1'b0);
        cycle(1'b1, I_C, 32'h314, 32'd0, 32'd0, 1'b1, 1'b1);
        chk("flush_drop_valid", 32'(ex_valid), 32'd0);
        cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
        chk("flush_drop_stays_empty", 32'(ex_valid), 32'd0);

        // Asynchronous reset in the middle of a stalled transfer.
        cycle(1'b1, I_A, 32'h400, 32'd0, 32'd0, 1'b0, 1'b0);
        cycle(1'b1, I_B, 32'h404, 32'd0, 32'd0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ex_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_pc", pc_out, 32'd0);
        chk("mid_rst_b", alu_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            ri = $urandom;
            if ($urandom_range(0, 9) < 9) begin
                ri[6:0] = opl[$urandom_range(0, 8)];
                case ($urandom_range(0, 3))
                    0:       ri[31:25] = 7'h00;
                    1:       ri[31:25] = 7'h20;
                    default: ;
                endcase
            end
            cycle(($urandom_range(0, 3) != 0), ri, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue stage that drives the ALU: decodes an RV32I instruction into the ALU's 5-bit control code and selects the operands.
- Registers the result behind a valid/ready handshake, with a one-entry skid buffer for full throughput under stall.
- Sits between register-file read (ID) and the ALU (EX) in the pipelined core; supports pipeline flush from branch/jump resolution.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- RESET_PC_VAL, 32'h0000_0000, reset value of the registered pc output.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush; kills held and incoming instructions.
- in_valid  in  1  ID presents an instruction.
- in_ready  out  1  stage can accept; registered.
- instr  in  32  raw instruction.
- pc  in  32  instruction address.
- rs1_data  in  32  forwarded rs1 value.
- rs2_data  in  32  forwarded rs2 value.
- ex_valid  out  1  output bundle valid.
- ex_ready  in  1  EX consumes the bundle.
- alu_a  out  32  ALU operand a_in.
- alu_b  out  32  ALU operand b_in.
- alu_ctrl  out  5  ALU control code.
- rd  out  5  destination register.
- reg_we  out  1  writeback enable.
- is_branch  out  1  conditional branch.
- is_jump  out  1  JAL/JALR.
- link_addr  out  32  pc+4.
- pc_out  out  32  pc of the issued instruction.
- illegal  out  1  unsupported encoding.

Behaviour:
- Reset (async, rst_n=0):
  - ex_valid=0, skid empty, in_ready=1.
  - All data outputs 0; pc_out=RESET_PC_VAL.
- ALU control codes:
  - ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLT 00101.
  - SLL 00110, SRL 00111, SRA 01000, SLLI 01001, SRAI 01010.
  - ADDI 01100, SLTI 01101, SLTIU 01110, XORI 01111, SRLI 10000, ORI 10001, ANDI 10010.
  - JALR 10011, SLTU 10100.
- Decode (combinational, registered on accept):
  - OP (0110011): a=rs1, b=rs2, reg_we=1. Control from funct3 and instr[30]. funct7 must be 0000000, or 0100000 for SUB/SRA only; anything else is illegal.
  - OP-IMM (0010011): a=rs1, b=sign-extended I-immediate, I-type codes. For shifts b=shamt zero-extended. SRAI requires instr[30]=1 with instr[31,29:25]=0; SLLI/SRLI require funct7=0.
  - LUI: a=0, b={imm[31:12],12'b0}, ADD.
  - AUIPC: a=pc, b=U-immediate, ADD.
  - JAL: a=pc, b=J-immediate, ADD, is_jump=1, reg_we=(rd!=0).
  - JALR: a=rs1, b=I-immediate, 10011, is_jump=1.
  - LOAD/STORE: a=rs1, b=I-/S-immediate, ADD. reg_we=1 for loads, 0 for stores.
  - BRANCH: a=rs1, b=rs2, reg_we=0, is_branch=1. BEQ/BNE→SUB; BLT/BGE→SLT; BLTU/BGEU→SLTU; funct3 010/011 illegal.
  - Illegal or unknown opcode: illegal=1, alu_ctrl=00000, reg_we=0, is_branch=is_jump=0.
  - reg_we is forced to 0 whenever rd=0.
- Handshake:
  - Input accepted when in_valid & in_ready.
  - Output consumed when ex_valid & ex_ready.
  - Output register loads from input when empty or consumed in the same cycle. Otherwise the accepted input goes to the skid register.
  - When the output is consumed and the skid is full, skid moves to output; a simultaneous input accept lands in the skid.
  - in_ready(next) = ~skid_valid(next).
  - Latency 1 cycle from accept to ex_valid. Order is strictly preserved; no drop, no duplication.
  - Output fields are stable while ex_valid & ~ex_ready.
- Flush:
  - Next edge: ex_valid=0, skid cleared, in_ready=1.
  - An input presented in the flush cycle is dropped.
  - Flush takes priority over accept and consume.
- Reset mid-transfer: all state is lost immediately; outputs return to reset values asynchronously.

Test Plan:
- Reset with ex_ready=1 and no input -> ex_valid=0, in_ready=1, alu_ctrl=00000, pc_out=0.
- instr=0x402080B3 (sub x1,x1,x2), rs1=5, rs2=3 -> next cycle ex_valid=1, alu_ctrl=00001, alu_a=5, alu_b=3, rd=1, reg_we=1.
- instr=0xFFF00113 (addi x2,x0,-1) -> alu_ctrl=01100, alu_b=0xFFFFFFFF, rd=2. Then instr=0x4030D093 (srai) -> alu_ctrl=01010, alu_b=3.
- ex_ready=0, three back-to-back valid instructions A, B, C:
  - A goes to the output, B to the skid; in_ready=0 after B; C is held.
  - Raise ex_ready -> A, B, C appear in order, one per cycle.
- Output and skid both full, flush=1 with in_valid=1 -> next cycle ex_valid=0, in_ready=1; the flushed-cycle instruction never appears.
- instr=0xFFFFFFFF -> illegal=1, reg_we=0, alu_ctrl=00000. BGEU (funct3 111) -> alu_ctrl=10100, is_branch=1, reg_we=0.
